// File: rtl/router_port_tx.sv
// rtl/router_port_tx.sv - per-port serial packet transmitter for the router ingress lane
// Byte beats go through a one-beat hold register and are serialized as address, pad, payload.
module router_port_tx #(
  parameter int ADDR_W     = 4,
  parameter int PAD_CYCLES = 5,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              din,
  output logic              frame_n,
  output logic              valid_n,
  output logic              busy,
  output logic              underrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STALL = 3'd4;

  localparam int MAX_AP = (ADDR_W > PAD_CYCLES) ? ADDR_W : PAD_CYCLES;
  localparam int MAXC   = (MAX_AP > DATA_W) ? MAX_AP : DATA_W;
  localparam int CNT_W  = $clog2(MAXC + 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] shift;
  logic              shift_last;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic              hold_last;
  logic              last_seen;

  logic              accept;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_last;
  logic              load;

  assign s_ready   = !hold_valid && !last_seen;
  assign accept    = s_valid && s_ready;
  // A beat accepted this cycle can feed the shifter directly, so a stall ends without an extra bubble.
  assign src_valid = hold_valid || accept;
  assign src_data  = hold_valid ? hold_data : s_data;
  assign src_last  = hold_valid ? hold_last : s_last;

  assign load = ((state == PAD)   && (cnt == CNT_W'(PAD_CYCLES - 1))) ||
                ((state == DATA)  && (cnt == CNT_W'(DATA_W - 1)) && !shift_last && src_valid) ||
                ((state == STALL) && src_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_sh    <= '0;
      shift      <= '0;
      shift_last <= 1'b0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      last_seen  <= 1'b0;
      din        <= 1'b0;
      frame_n    <= 1'b1;
      valid_n    <= 1'b1;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= s_data;
        hold_last  <= s_last;
        if (s_last) last_seen <= 1'b1;
      end

      if (load) begin
        state      <= DATA;
        cnt        <= '0;
        shift      <= src_data;
        shift_last <= src_last;
        hold_valid <= 1'b0;
        din        <= src_data[0];
        frame_n    <= (DATA_W == 1) && src_last;
        valid_n    <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= ADDR;
              cnt     <= '0;
              addr_sh <= s_addr;
              din     <= s_addr[0];
              frame_n <= 1'b0;
              valid_n <= 1'b1;
              busy    <= 1'b1;
            end
          end
          ADDR: begin
            if (cnt == CNT_W'(ADDR_W - 1)) begin
              state <= PAD;
              cnt   <= '0;
              din   <= 1'b1;
            end else begin
              cnt     <= cnt + 1'b1;
              addr_sh <= addr_sh >> 1;
              din     <= addr_sh[1];
            end
          end
          PAD: begin
            cnt <= cnt + 1'b1;
          end
          DATA: begin
            if (cnt == CNT_W'(DATA_W - 1)) begin
              din     <= 1'b0;
              valid_n <= 1'b1;
              if (shift_last) begin
                state     <= IDLE;
                frame_n   <= 1'b1;
                busy      <= 1'b0;
                last_seen <= 1'b0;
              end else begin
                state    <= STALL;
                underrun <= 1'b1;
              end
            end else begin
              cnt     <= cnt + 1'b1;
              shift   <= shift >> 1;
              din     <= shift[1];
              frame_n <= (cnt == CNT_W'(DATA_W - 2)) && shift_last;
            end
          end
          STALL: begin
          end
          default: begin
            state   <= IDLE;
            din     <= 1'b0;
            frame_n <= 1'b1;
            valid_n <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_port_tx.sv
// tb/tb_router_port_tx.sv - scoreboard bench for router_port_tx
// Expected lane cycles {din,frame_n,valid_n,underrun,busy} are queued per packet and popped each cycle.
module tb_router_port_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s_addr;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       din;
  logic       frame_n;
  logic       valid_n;
  logic       busy;
  logic       underrun;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
    int         delay;
  } beat_t;

  beat_t      beat_q[$];
  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  router_port_tx dut (
    .clk(clk), .reset(reset), .s_addr(s_addr), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_cycle(logic d, logic fn, logic vn, logic ur, logic bz);
    exp_q.push_back({d, fn, vn, ur, bz});
  endfunction

  function automatic void push_header(logic [3:0] addr);
    for (int i = 0; i < 4; i++) push_cycle(addr[i], 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic void push_byte(logic [7:0] data, logic last);
    for (int j = 0; j < 8; j++) push_cycle(data[j], last && (j == 7), 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic void push_idle();
    push_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic void push_stall(int n);
    for (int i = 0; i < n; i++) push_cycle(1'b0, 1'b0, 1'b1, (i == 0), 1'b1);
  endfunction

  function automatic void add_beat(logic [3:0] a, logic [7:0] d, logic l, int dly);
    beat_t b;
    b.addr = a; b.data = d; b.last = l; b.delay = dly;
    beat_q.push_back(b);
  endfunction

  // Presents queued beats; each beat waits its delay after the previous acceptance.
  task automatic drive_beats();
    beat_t b;
    int    guard;
    while (beat_q.size() > 0) begin
      b = beat_q.pop_front();
      s_valid = 1'b0;
      repeat (b.delay) begin @(posedge clk); #1; end
      s_valid = 1'b1; s_addr = b.addr; s_data = b.data; s_last = b.last;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!s_ready && guard < 200);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (din !== 1'b0)     begin errors++; $display("FAIL reset_din: got %b want 0", din); end
    checks++; if (frame_n !== 1'b1) begin errors++; $display("FAIL reset_frame_n: got %b want 1", frame_n); end
    checks++; if (valid_n !== 1'b1) begin errors++; $display("FAIL reset_valid_n: got %b want 1", valid_n); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    logic [4:0] e;
    int         guard = 0;
    add_beat(4'hA, 8'hC3, 1'b1, 0);
    push_header(4'hA); push_byte(8'hC3, 1'b1); push_idle(); push_idle();
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL single_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL single_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
  endtask

  task automatic test_multi_byte();
    logic [4:0] e;
    int         guard = 0;
    add_beat(4'h6, 8'h01, 1'b0, 0); add_beat(4'hF, 8'h80, 1'b0, 0); add_beat(4'h0, 8'hFF, 1'b1, 0);
    push_header(4'h6); push_byte(8'h01, 1'b0); push_byte(8'h80, 1'b0); push_byte(8'hFF, 1'b1); push_idle();
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL multi_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL multi_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
  endtask

  task automatic test_stall();
    logic [4:0] e;
    int         guard = 0;
    add_beat(4'h3, 8'h5A, 1'b0, 0); add_beat(4'h0, 8'hB4, 1'b1, 21);
    push_header(4'h3); push_byte(8'h5A, 1'b0); push_stall(5); push_byte(8'hB4, 1'b1); push_idle();
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL stall_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL stall_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_packet();
    logic [4:0] e;
    logic [7:0] d0 = 8'h96;
    int         guard = 0;
    add_beat(4'h9, d0, 1'b0, 0); add_beat(4'h0, 8'h11, 1'b1, 0);
    push_header(4'h9);
    for (int j = 0; j < 3; j++) push_cycle(d0[j], 1'b0, 1'b0, 1'b0, 1'b1);
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL rst_mid_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL rst_mid_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (frame_n !== 1'b1) begin errors++; $display("FAIL rst_mid_frame_n: got %b want 1", frame_n); end
    checks++; if (valid_n !== 1'b1) begin errors++; $display("FAIL rst_mid_valid_n: got %b want 1", valid_n); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_s_ready: got %b want 1", s_ready); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    guard = 0;
    add_beat(4'h5, 8'h5A, 1'b1, 0);
    push_header(4'h5); push_byte(8'h5A, 1'b1); push_idle();
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL rst_new_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL rst_new_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int         guard = 0;
    add_beat(4'hC, 8'hE1, 1'b1, 0); add_beat(4'h2, 8'h7E, 1'b1, 0);
    push_header(4'hC); push_byte(8'hE1, 1'b1); push_idle();
    push_header(4'h2); push_byte(8'h7E, 1'b1); push_idle(); push_idle();
    fork
      drive_beats();
      begin
        do begin @(negedge clk); guard++; end while (!(s_valid && s_ready) && guard < 100);
        checks++; if (!(s_valid && s_ready)) begin errors++; $display("FAIL b2b_accept: got 0 want 1"); end
        while (exp_q.size() > 0) begin
          @(negedge clk); e = exp_q.pop_front(); checks++;
          if ({din, frame_n, valid_n, underrun, busy} !== e) begin
            errors++; $display("FAIL b2b_wave: got %b want %b", {din, frame_n, valid_n, underrun, busy}, e);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single_byte();
    repeat (2) @(posedge clk); #1;
    test_multi_byte();
    repeat (2) @(posedge clk); #1;
    test_stall();
    repeat (2) @(posedge clk); #1;
    test_reset_mid_packet();
    repeat (2) @(posedge clk); #1;
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
